seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of each input word (4..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted out first and 0 = LSB first.
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_wr_valid, input, 1 bit: input word offered.
REQ-006 SHALL have port i_wr_data, input, DATA_W bits: input word.
REQ-007 SHALL have port o_wr_ready, output, 1 bit: word accepted when i_wr_valid && o_wr_ready.
REQ-008 SHALL have port i_pause, input, 1 bit: downstream hold; freezes bit emission.
REQ-009 SHALL have port o_valid, output, 1 bit: o_data carries a valid serial bit (feeds sequence detector i_valid).
REQ-010 SHALL have port o_data, output, 1 bit: serial bit (feeds sequence detector i_data).
REQ-011 SHALL have port o_last, output, 1 bit: high with the final bit of each word.
REQ-012 SHALL have port o_busy, output, 1 bit: FIFO non-empty or word in shifter.

Function
REQ-013 SHALL buffer accepted words in a 2-entry FIFO; o_wr_ready = FIFO count < 2, combinational from registered count only.
REQ-014 SHALL not accept a word when the FIFO is full, even if a pop occurs in the same cycle.
REQ-015 SHALL implement FSM states IDLE and SHIFT with a bit counter of width clog2(DATA_W).
REQ-016 IDLE: if FIFO non-empty and !i_pause, SHALL pop the head into the shift register, clear the counter, and enter SHIFT.
REQ-017 SHIFT: each cycle with !i_pause SHALL present the next bit on o_data with o_valid=1 (registered) and increment the counter.
REQ-018 SHALL assert o_last with bit index DATA_W-1; on that cycle, SHALL pop the next word if present and stay in SHIFT with no bubble, else return to IDLE.
REQ-019 Latency: a word accepted at cycle N into an empty, idle block SHALL produce its first o_valid bit at cycle N+2.
REQ-020 While i_pause=1, SHALL drive o_valid=0 and o_last=0 from the next cycle, with shifter, counter and FSM frozen; resumption continues from the held bit with no bit lost or repeated.
REQ-021 SHALL pass a simultaneous push and pop in the same cycle (count<2) with count unchanged and order preserved.
REQ-022 o_data SHALL hold its last value when o_valid=0.
REQ-023 o_busy SHALL fall on the cycle after the final o_last of the last buffered word.

Reset
REQ-024 On i_rst_n=0 at a clock edge, SHALL clear the FIFO (count 0), FSM to IDLE, counter 0, and o_valid, o_data, o_last, o_busy to 0; o_wr_ready SHALL be 1 in the following cycle.
REQ-025 Reset mid-word SHALL discard the partial word and all buffered words; no further bits from them SHALL appear.

Structure
REQ-026 Shared package ser_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the FIFO depth constant (2).
REQ-027 The FIFO SHALL be a sub-module ser_fifo2 (synchronous, 2 entries, push/pop/full/empty).

Verification
REQ-028 MSB_FIRST=1: write 8'hD0 -> o_data sequence 1,1,0,1,0,0,0,0 on cycles N+2..N+9, o_last only on N+9.
REQ-029 Back-to-back writes 8'hDD then 8'hBB -> 16 consecutive o_valid cycles, bits 11011101 10111011, o_last on cycles 8 and 16.
REQ-030 Hold i_pause=1 and offer 3 words -> two accepted, o_wr_ready=0 afterwards; third accepted one cycle after the first pop.
REQ-031 8'hD0 with i_pause pulsed high for 3 cycles after bit 2 -> o_valid low 3 cycles, then bits resume at bit 3; total 8 valid bits, unchanged.
REQ-032 Reset asserted after bit 4 of 8'hFF with 8'hAA queued -> all outputs 0 next cycle, no further o_valid, o_wr_ready=1.
REQ-033 MSB_FIRST=0: write 8'h0B -> bits 1,1,0,1,0,0,0,0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer slice.
// Holds the serializer FSM state encoding and the input FIFO depth.
// No logic lives here; both the FIFO and the serializer top import it.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ser_fifo2.sv
// Purpose: two-entry synchronous word buffer in front of the serializer shifter.
// Latency: a pushed word is visible at o_data (head) the cycle after the push.
// Backpressure: o_full is derived from the registered count; pushes while full are dropped.
module ser_fifo2
   import ser_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push_ok;
   logic          pop_ok;

   // Full/empty come straight from the registered count so ready never depends on a same-cycle pop.
   assign o_full  = (count == CNT_FULL);
   assign o_empty = (count == '0);
   assign o_data  = mem[rd_ptr];
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   // Storage array: written on accepted pushes only, no reset needed for payload.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// Purpose: buffers parallel words and emits them one bit per cycle, MSB or LSB first.
// Latency: word accepted in cycle N shows its first valid bit in cycle N+2; words chain with no bubble.
// Backpressure: o_wr_ready drops when both FIFO slots are full; i_pause freezes emission in place.
module seq_bit_serializer
   import ser_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_pause,
   output logic              o_valid,
   output logic              o_data,
   output logic              o_last,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   ser_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              valid_q, valid_d;
   logic              data_q, data_d;
   logic              last_q, last_d;

   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   // Bit that leaves the word first for the configured ordering.
   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   // Word with the emitted bit removed, next bit moved into the emit position.
   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   assign o_wr_ready = ~fifo_full;
   assign push       = i_wr_valid && o_wr_ready;
   assign cnt_inc    = cnt_q + 1'b1;

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_last  = last_q;
   assign o_busy  = !fifo_empty || (state_q == SHIFT);

   ser_fifo2 #(
      .W (DATA_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (i_wr_data),
      .i_pop   (pop),
      .o_data  (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Next-state and output decode; a pop also registers the new word's first bit so no cycle is lost.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      valid_d = 1'b0;
      data_d  = data_q;
      last_d  = 1'b0;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty && !i_pause) begin
               pop     = 1'b1;
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = advance(fifo_head);
               data_d  = first_bit(fifo_head);
               valid_d = 1'b1;
            end
         end
         SHIFT: begin
            if (!i_pause) begin
               if (cnt_q == LAST_IDX) begin
                  // Final bit is on the wire now: chain straight into the next word if one waits.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     cnt_d   = '0;
                     shreg_d = advance(fifo_head);
                     data_d  = first_bit(fifo_head);
                     valid_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d   = cnt_inc;
                  shreg_d = advance(shreg_q);
                  data_d  = first_bit(shreg_q);
                  valid_d = 1'b1;
                  last_d  = (cnt_inc == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter, shifter and registered serial outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         valid_q <= 1'b0;
         data_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one MSB-first and one LSB-first instance.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected bit streams are written out by hand from the input words.
module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pause;
   logic       wr_valid, wr_valid2;
   logic [7:0] wr_data, wr_data2;
   logic       wr_ready, vld, dat, lst, busy;
   logic       wr_ready2, vld2, dat2, lst2, busy2;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr_valid (wr_valid),
      .i_wr_data  (wr_data),
      .o_wr_ready (wr_ready),
      .i_pause    (pause),
      .o_valid    (vld),
      .o_data     (dat),
      .o_last     (lst),
      .o_busy     (busy)
   );

   seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr_valid (wr_valid2),
      .i_wr_data  (wr_data2),
      .o_wr_ready (wr_ready2),
      .i_pause    (pause),
      .o_valid    (vld2),
      .o_data     (dat2),
      .o_last     (lst2),
      .o_busy     (busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Samples n cycles starting at the current falling edge, driving pause from pmask after each sample.
   task automatic run(input int n, input logic [31:0] pmask, input bit lsb,
                      output logic [31:0] bits, output logic [31:0] lasts,
                      output int nv, output int ninv, output int nghost, output int nhold);
      logic v, d, l, prev;
      bits   = '0;
      lasts  = '0;
      nv     = 0;
      ninv   = 0;
      nghost = 0;
      nhold  = 0;
      prev   = lsb ? dat2 : dat;
      for (int i = 0; i < n; i++) begin
         v = lsb ? vld2 : vld;
         d = lsb ? dat2 : dat;
         l = lsb ? lst2 : lst;
         if (v) begin
            bits  = {bits[30:0], d};
            lasts = {lasts[30:0], l};
            nv++;
         end else begin
            ninv++;
            if (l) nghost++;
            if (d !== prev) nhold++;
         end
         prev  = d;
         pause = pmask[i];
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] bits, lasts;
      int nv, ninv, nghost, nhold;

      rst_n     = 1'b0;
      pause     = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = 8'h00;
      wr_valid2 = 1'b0;
      wr_data2  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_outputs", 32'({vld, dat, lst, busy}), 32'h0);
      check("rst_ready", 32'(wr_ready), 32'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single word 0xD0, MSB first: first bit at N+2, o_last on the eighth bit
      wr_valid = 1'b1; wr_data = 8'hD0;
      @(negedge clk);
      wr_valid = 1'b0;
      check("d0_not_early", 32'(vld), 32'h0);
      check("d0_busy", 32'(busy), 32'h1);
      @(negedge clk);
      run(8, 32'h0, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("d0_bits", bits, 32'hD0);
      check("d0_last", lasts, 32'h01);
      check("d0_contig", 32'(nv), 32'd8);
      check("d0_idle_after", 32'({vld, busy}), 32'h0);

      // Back-to-back 0xDD, 0xBB: 16 consecutive bits, no bubble
      wr_valid = 1'b1; wr_data = 8'hDD;
      @(negedge clk);
      wr_data = 8'hBB;
      @(negedge clk);
      wr_valid = 1'b0;
      run(16, 32'h0, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("b2b_bits", bits, 32'hDDBB);
      check("b2b_last", lasts, 32'h0101);
      check("b2b_contig", 32'(nv), 32'd16);
      check("b2b_idle_after", 32'({vld, busy}), 32'h0);

      // Paused with three words offered: two accepted, third one cycle after the first pop
      pause = 1'b1; wr_valid = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      check("fill_ready_one", 32'(wr_ready), 32'h1);
      wr_data = 8'h3C;
      @(negedge clk);
      check("fill_ready_zero", 32'(wr_ready), 32'h0);
      check("fill_paused_quiet", 32'(vld), 32'h0);
      wr_data = 8'hF0;
      @(negedge clk);
      check("fill_full_hold", 32'(wr_ready), 32'h0);
      pause = 1'b0;
      @(negedge clk);
      check("fill_pop_frees", 32'(wr_ready), 32'h1);
      check("fill_a_bit1", 32'({vld, dat}), 32'h3);
      @(negedge clk);
      wr_valid = 1'b0;
      check("fill_third_taken", 32'(wr_ready), 32'h0);
      check("fill_a_bit2", 32'({vld, dat}), 32'h2);
      @(negedge clk);
      run(22, 32'h0, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("fill_bits", bits, 32'h253CF0);
      check("fill_last", lasts, 32'h010101);
      check("fill_contig", 32'(nv), 32'd22);
      check("fill_idle_after", 32'({vld, busy}), 32'h0);

      // 0xD0 with pause high for three cycles after bit 2
      wr_valid = 1'b1; wr_data = 8'hD0;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      run(12, 32'h0000_000E, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("pause_bits", bits, 32'hD0);
      check("pause_nvalid", 32'(nv), 32'd8);
      check("pause_gap", 32'(ninv), 32'd4);
      check("pause_last", lasts, 32'h01);
      check("pause_no_ghost_last", 32'(nghost), 32'd0);
      check("pause_data_hold", 32'(nhold), 32'd0);

      // Reset after bit 4 of 0xFF with 0xAA queued
      wr_valid = 1'b1; wr_data = 8'hFF;
      @(negedge clk);
      wr_data = 8'hAA;
      @(negedge clk);
      wr_valid = 1'b0;
      check("rstmid_bit1", 32'({vld, dat}), 32'h3);
      @(negedge clk);
      run(2, 32'h0, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("rstmid_bits23", bits, 32'h3);
      check("rstmid_bit4", 32'({vld, dat}), 32'h3);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_outputs", 32'({vld, dat, lst, busy}), 32'h0);
      check("rstmid_ready", 32'(wr_ready), 32'h1);
      rst_n = 1'b1;
      @(negedge clk);
      run(12, 32'h0, 1'b0, bits, lasts, nv, ninv, nghost, nhold);
      check("rstmid_no_more_bits", 32'(nv), 32'd0);
      check("rstmid_not_busy", 32'(busy), 32'h0);

      // LSB-first instance: 0x0B emits 1,1,0,1,0,0,0,0
      wr_valid2 = 1'b1; wr_data2 = 8'h0B;
      @(negedge clk);
      wr_valid2 = 1'b0;
      check("lsb_not_early", 32'(vld2), 32'h0);
      @(negedge clk);
      run(8, 32'h0, 1'b1, bits, lasts, nv, ninv, nghost, nhold);
      check("lsb_bits", bits, 32'hD0);
      check("lsb_last", lasts, 32'h01);
      check("lsb_contig", 32'(nv), 32'd8);
      check("lsb_idle_after", 32'({vld2, busy2}), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
